// File: rtl/lbm_dir_sequencer.sv
// D2Q9 velocity-vector sequencer: sweeps nodes x directions and issues sign-extended (cx, cy) beats.
// Define LBM_SKIP_REST_DIR_EN to drop the rest direction (0) and issue 8 beats per node.
module lbm_dir_sequencer #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 9,
  parameter int C_MAG     = 1,
  parameter int NUM_NODES = 16,
  parameter int NODE_W    = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_N,
  input  logic                    Start,
  input  logic                    Abort,
  input  logic                    Dir_Ready,
  output logic                    Dir_Valid,
  output logic [3:0]              Dir_Idx,
  output logic [NODE_W-1:0]       Node_Idx,
  output logic signed [OUT_W-1:0] Cx_Out,
  output logic signed [OUT_W-1:0] Cy_Out,
  output logic                    Last_Dir,
  output logic                    Last_Node,
  output logic                    Busy,
  output logic                    Done
);

`ifdef LBM_SKIP_REST_DIR_EN
  localparam logic [3:0] FIRST_DIR = 4'd1;
`else
  localparam logic [3:0] FIRST_DIR = 4'd0;
`endif
  localparam logic [3:0]        LAST_DIR  = 4'd8;
  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                    state_reg;
  logic signed [OUT_W-1:0]   cx_tab [16];
  logic signed [OUT_W-1:0]   cy_tab [16];
  logic [3:0]                ld_dir;
  logic [NODE_W-1:0]         ld_node;

  // Table padded to 16 entries so any 4-bit index is in range; unused slots read 0.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_tab
      localparam int CX = (gi == 1 || gi == 5 || gi == 8) ? 1 :
                          (gi == 3 || gi == 6 || gi == 7) ? -1 : 0;
      localparam int CY = (gi == 2 || gi == 5 || gi == 6) ? 1 :
                          (gi == 4 || gi == 7 || gi == 8) ? -1 : 0;
      localparam logic signed [IN_W-1:0] CX_ENT = IN_W'(CX * C_MAG);
      localparam logic signed [IN_W-1:0] CY_ENT = IN_W'(CY * C_MAG);
      // Signed size cast replicates the entry MSB into the wider output.
      assign cx_tab[gi] = OUT_W'(CX_ENT);
      assign cy_tab[gi] = OUT_W'(CY_ENT);
    end
  endgenerate

  // Index pair to load on the next edge: sweep origin from IDLE, otherwise the successor beat.
  always_comb begin
    ld_dir  = FIRST_DIR;
    ld_node = '0;
    if (state_reg == ISSUE) begin
      if (Last_Dir) begin
        ld_dir  = FIRST_DIR;
        ld_node = Node_Idx + NODE_W'(1);
      end else begin
        ld_dir  = Dir_Idx + 4'd1;
        ld_node = Node_Idx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_reg <= IDLE;
      Dir_Valid <= 1'b0;
      Dir_Idx   <= '0;
      Node_Idx  <= '0;
      Cx_Out    <= '0;
      Cy_Out    <= '0;
      Last_Dir  <= 1'b0;
      Last_Node <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          Done <= 1'b0;
          if (Start && !Abort) begin
            state_reg <= ISSUE;
            Dir_Valid <= 1'b1;
            Busy      <= 1'b1;
            Dir_Idx   <= ld_dir;
            Node_Idx  <= ld_node;
            Cx_Out    <= cx_tab[ld_dir];
            Cy_Out    <= cy_tab[ld_dir];
            Last_Dir  <= (ld_dir == LAST_DIR);
            Last_Node <= (ld_node == LAST_NODE);
          end
        end
        ISSUE: begin
          if (Abort || (Dir_Ready && Last_Dir && Last_Node)) begin
            state_reg <= Abort ? IDLE : DONE;
            Done      <= !Abort;
            Dir_Valid <= 1'b0;
            Busy      <= 1'b0;
            Dir_Idx   <= '0;
            Node_Idx  <= '0;
            Cx_Out    <= '0;
            Cy_Out    <= '0;
            Last_Dir  <= 1'b0;
            Last_Node <= 1'b0;
          end else if (Dir_Ready) begin
            Dir_Idx   <= ld_dir;
            Node_Idx  <= ld_node;
            Cx_Out    <= cx_tab[ld_dir];
            Cy_Out    <= cy_tab[ld_dir];
            Last_Dir  <= (ld_dir == LAST_DIR);
            Last_Node <= (ld_node == LAST_NODE);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          Done      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          Dir_Valid <= 1'b0;
          Busy      <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbm_dir_sequencer.sv
// Self-checking bench for lbm_dir_sequencer: directed scenarios plus randomized handshakes
// compared against a beat-list reference model.
module tb_lbm_dir_sequencer;

  localparam int IN_W      = 8;
  localparam int OUT_W     = 9;
  localparam int C_MAG     = 1;
  localparam int NUM_NODES = 2;
  localparam int NODE_W    = 4;
`ifdef LBM_SKIP_REST_DIR_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int PER_NODE = 9 - FIRST;
  localparam int TOTAL    = NUM_NODES * PER_NODE;

  logic              Clk = 1'b0;
  logic              Reset_N = 1'b0;
  logic              Start = 1'b0;
  logic              Abort = 1'b0;
  logic              Dir_Ready = 1'b0;
  logic              Dir_Valid;
  logic [3:0]        Dir_Idx;
  logic [NODE_W-1:0] Node_Idx;
  logic [OUT_W-1:0]  Cx_Out;
  logic [OUT_W-1:0]  Cy_Out;
  logic              Last_Dir;
  logic              Last_Node;
  logic              Busy;
  logic              Done;

  lbm_dir_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .C_MAG(C_MAG), .NUM_NODES(NUM_NODES), .NODE_W(NODE_W)
  ) dut (
    .Clk(Clk), .Reset_N(Reset_N), .Start(Start), .Abort(Abort), .Dir_Ready(Dir_Ready),
    .Dir_Valid(Dir_Valid), .Dir_Idx(Dir_Idx), .Node_Idx(Node_Idx),
    .Cx_Out(Cx_Out), .Cy_Out(Cy_Out), .Last_Dir(Last_Dir), .Last_Node(Last_Node),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;

  // Expected beat list, built directly from the D2Q9 table.
  int               exp_node [$];
  int               exp_dir  [$];
  logic [OUT_W-1:0] exp_cx   [$];
  logic [OUT_W-1:0] exp_cy   [$];
  int               exp_ld   [$];
  int               exp_ln   [$];

  // Model state: sweep active, beat pointer, Done pending, outputs expected cleared.
  bit m_active = 0;
  int m_k      = 0;
  bit m_done   = 0;
  bit m_zero   = 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", 32'(Dir_Valid), 32'(m_active));
    check_eq("busy",  32'(Busy),      32'(m_active));
    check_eq("done",  32'(Done),      32'(m_done));
    if (m_active) begin
      check_eq("node",      32'(Node_Idx),  32'(exp_node[m_k]));
      check_eq("dir",       32'(Dir_Idx),   32'(exp_dir[m_k]));
      check_eq("cx",        32'(Cx_Out),    32'(exp_cx[m_k]));
      check_eq("cy",        32'(Cy_Out),    32'(exp_cy[m_k]));
      check_eq("last_dir",  32'(Last_Dir),  32'(exp_ld[m_k]));
      check_eq("last_node", 32'(Last_Node), 32'(exp_ln[m_k]));
    end else if (m_zero) begin
      check_eq("idle_zero", {Node_Idx, Dir_Idx, Cx_Out, Cy_Out, Last_Dir, Last_Node}, 32'd0);
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, check after it.
  task automatic step(input logic st, input logic ab, input logic rdy);
    Start = st;
    Abort = ab;
    Dir_Ready = rdy;
    if (Reset_N && Dir_Valid && rdy && !ab) n_beats++;
    @(posedge Clk);
    if (!Reset_N) begin
      m_active = 0; m_k = 0; m_done = 0; m_zero = 1;
    end else if (m_active) begin
      if (ab) begin
        m_active = 0; m_k = 0; m_zero = 1;
      end else if (rdy) begin
        m_k++;
        if (m_k == TOTAL) begin
          m_active = 0; m_k = 0; m_done = 1; m_zero = 0;
        end
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (st && !ab) begin
      m_active = 1; m_k = 0; m_zero = 0;
    end
    #1;
    check_outputs();
    $display("t=%0t st=%0b ab=%0b rdy=%0b -> v=%0b node=%0d dir=%0d cx=%0h cy=%0h ld=%0b ln=%0b done=%0b",
             $time, st, ab, rdy, Dir_Valid, Node_Idx, Dir_Idx, Cx_Out, Cy_Out, Last_Dir, Last_Node, Done);
  endtask

  task automatic run_until_idle(input int budget);
    int c = 0;
    while ((m_active || m_done) && c < budget) begin
      step(0, 0, 1);
      c++;
    end
    if (c >= budget) check_eq("timeout_idle", 32'd1, 32'd0);
  endtask

  task automatic run_to(input int node, input int dir);
    int c = 0;
    while (!(Dir_Valid && int'(Node_Idx) == node && int'(Dir_Idx) == dir) && c < 200) begin
      step(0, 0, 1);
      c++;
    end
    if (c >= 200) check_eq("timeout_seek", 32'd1, 32'd0);
  endtask

  initial begin
    int cxv [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    int cyv [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
    int c;
    bit st, ab, rdy;

    for (int n = 0; n < NUM_NODES; n++) begin
      for (int d = FIRST; d <= 8; d++) begin
        exp_node.push_back(n);
        exp_dir.push_back(d);
        exp_cx.push_back(OUT_W'(cxv[d] * C_MAG));
        exp_cy.push_back(OUT_W'(cyv[d] * C_MAG));
        exp_ld.push_back(d == 8 ? 1 : 0);
        exp_ln.push_back(n == NUM_NODES - 1 ? 1 : 0);
      end
    end

    // Power-on reset
    step(0, 0, 0);
    step(0, 0, 0);
    Reset_N = 1'b1;
    step(0, 0, 0);

    // Reset in the middle of a sweep, then a clean restart at node 0
    step(1, 0, 1);
    repeat (6) step(0, 0, $urandom_range(0, 1) == 1);
    Reset_N = 1'b0;
    step(0, 0, 1);
    step(0, 0, 1);
    Reset_N = 1'b1;
    step(1, 0, 1);
    run_until_idle(200);

    // Full back-to-back sweep with Done latency
    step(1, 0, 1);
    c = 0;
    while (!Done && c < 200) begin
      step(0, 0, 1);
      c++;
    end
    // c edges after the Start edge: Done occupies cycle c+1 counting the Start cycle as 0.
    check_eq("done_latency", 32'(c), 32'(TOTAL));
    step(0, 0, 1);

    // Stall on direction 5: ready 0,0 then 1
    step(1, 0, 1);
    run_to(0, 5);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    run_until_idle(200);

    // Start re-pulsed while busy must not disturb the sweep
    n_beats = 0;
    step(1, 0, 1);
    run_to(0, 2);
    step(1, 0, 1);
    run_until_idle(200);
    check_eq("beats_total", 32'(n_beats), 32'(TOTAL));

    // Abort mid-sweep with a simultaneous Start; no Done afterwards
    step(1, 0, 1);
    run_to(1, 4);
    step(1, 1, 1);
    repeat (3) step(0, 0, 1);
    // Abort and Start together in IDLE: remain idle
    step(1, 1, 1);
    step(0, 0, 1);

    // Randomized sweeps with stalls, stray Starts and rare Aborts
    for (int s = 0; s < 8; s++) begin
      step(1, 0, $urandom_range(0, 1) == 1);
      c = 0;
      while ((m_active || m_done) && c < 600) begin
        st  = ($urandom_range(0, 9) == 0);
        ab  = ($urandom_range(0, 149) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        step(st, ab, rdy);
        c++;
      end
      if (c >= 600) check_eq("timeout_rand", 32'd1, 32'd0);
      step(0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
